// File: rtl/cache_tag_lookup_if.sv
// Request/response, fill and flush bundle between the cache controller and the tag store.
// The controller takes the master side; the tag store takes the slave side.
interface cache_tag_lookup_if #(
   parameter int s_offset = 5,
   parameter int s_index  = 3,
   parameter int s_tag    = 32 - s_offset - s_index,
   parameter int num_ways = 2,
   parameter int s_way    = $clog2(num_ways)
);
   logic                req_valid;
   logic [31:0]         req_addr;
   logic                req_ready;
   logic                rsp_valid;
   logic                rsp_hit;
   logic [s_way-1:0]    rsp_way;
   logic [s_way-1:0]    rsp_victim;
   logic [s_tag-1:0]    rsp_tag;
   logic [s_index-1:0]  rsp_index;
   logic [s_offset-1:0] rsp_offset;
   logic                fill_valid;
   logic [s_way-1:0]    fill_way;
   logic [31:0]         fill_addr;
   logic                inv_all;
   logic                busy;

   modport master (
      output req_valid, req_addr, fill_valid, fill_way, fill_addr, inv_all,
      input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_victim,
             rsp_tag, rsp_index, rsp_offset, busy
   );

   modport slave (
      input  req_valid, req_addr, fill_valid, fill_way, fill_addr, inv_all,
      output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_victim,
             rsp_tag, rsp_index, rsp_offset, busy
   );
endinterface

// File: rtl/cache_tag_lookup.sv
// N-way set-associative tag store with a one-cycle registered lookup, tree-PLRU
// replacement, line fills and a multi-cycle invalidate-all sweep.
module cache_tag_lookup #(
   parameter int s_offset = 5,
   parameter int s_index  = 3,
   parameter int s_tag    = 32 - s_offset - s_index,
   parameter int num_ways = 2,
   parameter int s_way    = $clog2(num_ways)
) (
   input logic               clk,
   input logic               rst,
   cache_tag_lookup_if.slave bus
);

   localparam int sets   = 2 ** s_index;
   localparam int s_plru = num_ways - 1;

   typedef enum logic {
      IDLE,
      SWEEP
   } state_t;

   state_t state, next_state;
   logic [s_index-1:0] sweep_cnt;

   logic [s_tag-1:0]    tag_mem   [sets][num_ways];
   logic [num_ways-1:0] valid_mem [sets];
   logic [s_plru-1:0]   plru_mem  [sets];

   logic [s_tag-1:0]    req_tag;
   logic [s_index-1:0]  req_index;
   logic [s_offset-1:0] req_offset;
   logic [s_tag-1:0]    fill_tag;
   logic [s_index-1:0]  fill_index;
   logic                unused_fill_offset;

   logic                accept;
   logic [num_ways-1:0] match;
   logic                hit;
   logic [s_way-1:0]    hit_way;
   logic [s_way-1:0]    victim;

   assign req_tag            = bus.req_addr[31:32-s_tag];
   assign req_index          = bus.req_addr[s_offset+s_index-1:s_offset];
   assign req_offset         = bus.req_addr[s_offset-1:0];
   assign fill_tag           = bus.fill_addr[31:32-s_tag];
   assign fill_index         = bus.fill_addr[s_offset+s_index-1:s_offset];
   assign unused_fill_offset = ^bus.fill_addr[s_offset-1:0];

   assign bus.req_ready = (state == IDLE) && !bus.fill_valid && !bus.inv_all;
   assign bus.busy      = (state == SWEEP);
   assign accept        = bus.req_valid && bus.req_ready;

   // The tree is walked as a 1-based heap (root 1, children 2n and 2n+1); after
   // s_way steps the low s_way bits of the node number are exactly the leaf way.
   function automatic logic [s_way-1:0] plru_victim(input logic [s_plru-1:0] bits);
      logic [num_ways-1:0] tree;
      logic [s_way-1:0]    node;
      tree = {bits, 1'b0};
      node = s_way'(1);
      for (int lvl = 0; lvl < s_way; lvl++) begin
         node = (node << 1) | s_way'(tree[node]);
      end
      return node;
   endfunction

   function automatic logic [s_plru-1:0] plru_touch(input logic [s_plru-1:0] bits,
                                                    input logic [s_way-1:0]  way);
      logic [num_ways-1:0] tree;
      logic [s_way-1:0]    node;
      logic [s_way-1:0]    path;
      tree = {bits, 1'b0};
      node = s_way'(1);
      path = way;
      for (int lvl = 0; lvl < s_way; lvl++) begin
         tree[node] = ~path[s_way-1];
         node       = (node << 1) | s_way'(path[s_way-1]);
         path       = path << 1;
      end
      return tree[num_ways-1:1];
   endfunction

   for (genvar w = 0; w < num_ways; w++) begin : g_match
      assign match[w] = valid_mem[req_index][w] && (tag_mem[req_index][w] == req_tag);
   end

   // Lowest-numbered invalid way wins over the PLRU choice.
   always_comb begin
      hit     = |match;
      hit_way = '0;
      victim  = plru_victim(plru_mem[req_index]);
      for (int w = 0; w < num_ways; w++) begin
         if (match[w]) hit_way = hit_way | s_way'(w);
      end
      for (int w = num_ways - 1; w >= 0; w--) begin
         if (!valid_mem[req_index][w]) victim = s_way'(w);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.inv_all) next_state = SWEEP;
         SWEEP:   if (sweep_cnt == '1) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || state == IDLE) sweep_cnt <= '0;
      else                      sweep_cnt <= sweep_cnt + 1'b1;
   end

   // Fills take priority over lookups, so a fill and a PLRU hit update never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < sets; s++) begin
            valid_mem[s] <= '0;
            plru_mem[s]  <= '0;
         end
      end else if (state == SWEEP) begin
         valid_mem[sweep_cnt] <= '0;
         plru_mem[sweep_cnt]  <= '0;
      end else if (bus.fill_valid) begin
         valid_mem[fill_index][bus.fill_way] <= 1'b1;
         plru_mem[fill_index] <= plru_touch(plru_mem[fill_index], bus.fill_way);
      end else if (accept && hit) begin
         plru_mem[req_index] <= plru_touch(plru_mem[req_index], hit_way);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && state == IDLE && bus.fill_valid) begin
         tag_mem[fill_index][bus.fill_way] <= fill_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rsp_valid  <= 1'b0;
         bus.rsp_hit    <= 1'b0;
         bus.rsp_way    <= '0;
         bus.rsp_victim <= '0;
         bus.rsp_tag    <= '0;
         bus.rsp_index  <= '0;
         bus.rsp_offset <= '0;
      end else begin
         bus.rsp_valid <= accept;
         if (accept) begin
            bus.rsp_hit    <= hit;
            bus.rsp_way    <= hit_way;
            bus.rsp_victim <= victim;
            bus.rsp_tag    <= req_tag;
            bus.rsp_index  <= req_index;
            bus.rsp_offset <= req_offset;
         end
      end
   end

   a_single_match : assert property (@(posedge clk) disable iff (rst)
      accept |-> $onehot0(match));

   a_no_fill_in_sweep : assert property (@(posedge clk) disable iff (rst)
      (state == SWEEP) |-> !bus.fill_valid);

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Randomized and directed bench for cache_tag_lookup, checked against a
// set/way array model that tracks the most recently used way per set.
module tb_cache_tag_lookup;

   localparam int s_offset = 5;
   localparam int s_index  = 3;
   localparam int s_tag    = 32 - s_offset - s_index;
   localparam int num_ways = 2;
   localparam int s_way    = $clog2(num_ways);
   localparam int sets     = 2 ** s_index;

   logic clk;
   logic rst;

   cache_tag_lookup_if #(
      .s_offset(s_offset), .s_index(s_index), .s_tag(s_tag),
      .num_ways(num_ways), .s_way(s_way)
   ) bus ();

   cache_tag_lookup #(
      .s_offset(s_offset), .s_index(s_index), .s_tag(s_tag),
      .num_ways(num_ways), .s_way(s_way)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Reference state: two ways per set, so pseudo-LRU reduces to "not the MRU way".
   bit m_valid [sets][num_ways];
   int m_tag   [sets][num_ways];
   int m_mru   [sets];
   int sweep_left;
   int sweep_pos;

   function automatic int tag_of(input logic [31:0] a);
      return int'(a / (1 << (s_offset + s_index)));
   endfunction

   function automatic int index_of(input logic [31:0] a);
      return int'((a / (1 << s_offset)) % sets);
   endfunction

   function automatic int offset_of(input logic [31:0] a);
      return int'(a % (1 << s_offset));
   endfunction

   function automatic void clear_set(input int s);
      for (int w = 0; w < num_ways; w++) m_valid[s][w] = 1'b0;
      m_mru[s] = num_ways - 1;
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < sets; s++) clear_set(s);
      sweep_left = 0;
      sweep_pos  = 0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      else
         passes++;
   endtask

   // Called on a falling edge: drives one cycle, predicts, then checks on the next falling edge.
   task automatic applyStimulus(input bit rv, input logic [31:0] ra, input bit fv, input int fw,
                                input logic [31:0] fa, input bit iv, input bit rs);
      bit exp_ready, exp_accept, exp_hit;
      int exp_way, exp_victim, idx, fi;
      rst            = rs;
      bus.req_valid  = rv;
      bus.req_addr   = ra;
      bus.fill_valid = fv;
      bus.fill_way   = s_way'(fw);
      bus.fill_addr  = fa;
      bus.inv_all    = iv;
      #1;
      exp_ready = (sweep_left == 0) && !fv && !iv;
      checkOutput("req_ready", bus.req_ready, exp_ready);
      exp_accept = rv && exp_ready && !rs;
      idx        = index_of(ra);
      exp_hit    = 1'b0;
      exp_way    = 0;
      for (int w = 0; w < num_ways; w++) begin
         if (m_valid[idx][w] && m_tag[idx][w] == tag_of(ra)) begin
            exp_hit = 1'b1;
            exp_way = w;
         end
      end
      exp_victim = -1;
      for (int w = num_ways - 1; w >= 0; w--) if (!m_valid[idx][w]) exp_victim = w;
      if (exp_victim < 0) exp_victim = 1 - m_mru[idx];

      @(posedge clk);
      if (rs) begin
         model_reset();
      end else if (sweep_left > 0) begin
         clear_set(sweep_pos);
         sweep_pos++;
         sweep_left--;
      end else begin
         if (fv) begin
            fi             = index_of(fa);
            m_valid[fi][fw] = 1'b1;
            m_tag[fi][fw]   = tag_of(fa);
            m_mru[fi]       = fw;
         end
         if (iv) begin
            sweep_left = sets;
            sweep_pos  = 0;
         end
         if (exp_accept && exp_hit) m_mru[idx] = exp_way;
      end

      @(negedge clk);
      checkOutput("rsp_valid", bus.rsp_valid, exp_accept);
      if (exp_accept) begin
         checkOutput("rsp_hit",    bus.rsp_hit,    exp_hit);
         checkOutput("rsp_way",    bus.rsp_way,    exp_way);
         checkOutput("rsp_victim", bus.rsp_victim, exp_victim);
         checkOutput("rsp_tag",    bus.rsp_tag,    tag_of(ra));
         checkOutput("rsp_index",  bus.rsp_index,  idx);
         checkOutput("rsp_offset", bus.rsp_offset, offset_of(ra));
      end
      if (rs) begin
         checkOutput("rst_rsp_hit",    bus.rsp_hit,    0);
         checkOutput("rst_rsp_way",    bus.rsp_way,    0);
         checkOutput("rst_rsp_victim", bus.rsp_victim, 0);
         checkOutput("rst_rsp_tag",    bus.rsp_tag,    0);
      end
      checkOutput("busy", bus.busy, sweep_left > 0);
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic req(input logic [31:0] a);
      applyStimulus(1, a, 0, 0, 0, 0, 0);
   endtask

   task automatic fill(input int way, input logic [31:0] a);
      applyStimulus(0, 0, 1, way, a, 0, 0);
   endtask

   // Refill an existing tag into its own way so a set never holds duplicates.
   function automatic int pick_way(input logic [31:0] a);
      int s;
      s = index_of(a);
      for (int w = 0; w < num_ways; w++)
         if (m_valid[s][w] && m_tag[s][w] == tag_of(a)) return w;
      return int'($urandom_range(0, num_ways - 1));
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = ($urandom_range(0, 3) << (s_offset + s_index))
        | ($urandom_range(0, sets - 1) << s_offset)
        | $urandom_range(0, (1 << s_offset) - 1);
      return a;
   endfunction

   initial begin
      logic [31:0] ra, fa;
      bit rv, fv, iv, rs;
      int fw;

      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_addr   = '0;
      bus.fill_valid = 1'b0;
      bus.fill_way   = '0;
      bus.fill_addr  = '0;
      bus.inv_all    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_reset();

      $display("[TB] reset and first lookup");
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      idle();
      req(32'h0000_1040);
      idle();

      $display("[TB] fill and hit");
      fill(0, 32'h0000_1040);
      req(32'h0000_105C);

      $display("[TB] PLRU ordering");
      fill(1, 32'h0000_2040);
      req(32'h0000_1040);
      req(32'h0000_3040);
      req(32'h0000_2040);
      req(32'h0000_3040);

      $display("[TB] fill blocks a same-cycle request");
      applyStimulus(1, 32'h0000_4040, 1, 0, 32'h0000_4040, 0, 0);
      req(32'h0000_4040);

      $display("[TB] invalidate-all sweep");
      for (int s = 0; s < sets; s++) fill(0, 32'h0000_1000 | (s << s_offset));
      applyStimulus(1, 32'h0000_1040, 0, 0, 0, 1, 0);
      for (int c = 0; c < sets; c++) req(32'h0000_1040);
      req(32'h0000_1040);
      req(32'h0000_1060);

      $display("[TB] reset in the middle of a sweep");
      for (int s = 0; s < sets; s++) fill(1, 32'h0000_5000 | (s << s_offset));
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      idle();
      idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      for (int s = 0; s < sets; s++) req(32'h0000_5000 | (s << s_offset));

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         ra = rand_addr();
         fa = rand_addr();
         rv = ($urandom_range(0, 99) < 70);
         rs = ($urandom_range(0, 199) < 2);
         if (sweep_left > 0) begin
            fv = 1'b0;
            iv = ($urandom_range(0, 9) < 2);
         end else begin
            fv = ($urandom_range(0, 99) < 20);
            iv = ($urandom_range(0, 99) < 3);
         end
         fw = pick_way(fa);
         applyStimulus(rv, ra, fv, fw, fa, iv, rs);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
